// File: rtl/register_status_controller_if.sv
// Handshake and table-port bundle between the issue/commit/flush logic and
// the register status table write controller.
interface register_status_controller_if #(
    parameter int unsigned REGISTER_NUMBER_LOG     = 5,
    parameter int unsigned REORDER_BUFFER_SIZE_LOG = 3
);
    logic                               issueValid;
    logic                               issueReady;
    logic [REGISTER_NUMBER_LOG-1:0]     issueDest;
    logic [REORDER_BUFFER_SIZE_LOG-1:0] issueTag;
    logic                               commitValid;
    logic [REGISTER_NUMBER_LOG-1:0]     commitDest;
    logic [REORDER_BUFFER_SIZE_LOG-1:0] commitTag;
    logic                               flush;
    logic                               flushBusy;
    logic [REGISTER_NUMBER_LOG-1:0]     tableReadIndex;
    logic [REORDER_BUFFER_SIZE_LOG:0]   tableReadValue;
    logic                               tableWriteEnable;
    logic [REGISTER_NUMBER_LOG-1:0]     tableWriteIndex;
    logic [REORDER_BUFFER_SIZE_LOG:0]   tableWriteValue;

    modport slave (
        input  issueValid, issueDest, issueTag,
        input  commitValid, commitDest, commitTag,
        input  flush, tableReadValue,
        output issueReady, flushBusy, tableReadIndex,
        output tableWriteEnable, tableWriteIndex, tableWriteValue
    );

    modport master (
        output issueValid, issueDest, issueTag,
        output commitValid, commitDest, commitTag,
        output flush, tableReadValue,
        input  issueReady, flushBusy, tableReadIndex,
        input  tableWriteEnable, tableWriteIndex, tableWriteValue
    );
endinterface

// File: rtl/register_status_controller.sv
// Single write port arbiter for the register status table: flush walk,
// commit-time release and issue-time rename, in that priority order.
module register_status_controller #(
    parameter int unsigned REGISTER_NUMBER_LOG     = 5,
    parameter int unsigned REORDER_BUFFER_SIZE_LOG = 3
) (
    input logic                         clk,
    input logic                         reset,
    register_status_controller_if.slave bus
);
    localparam int unsigned RW        = REGISTER_NUMBER_LOG;
    localparam int unsigned TW        = REORDER_BUFFER_SIZE_LOG;
    localparam int unsigned VW        = TW + 1;
    localparam int unsigned REG_COUNT = 2 ** RW;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] flush_index;
    logic [RW-1:0] flush_index_next;
    logic          commit_match_c;

    // Entry still names the committing tag, so the commit may release it.
    assign commit_match_c = bus.commitValid
                         && (bus.commitDest != '0)
                         && bus.tableReadValue[TW]
                         && (bus.tableReadValue[TW-1:0] == bus.commitTag);

    assign bus.tableReadIndex = bus.commitDest;

    // State register; reset lands in FLUSH so the walk clears the table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FLUSH;
            flush_index <= RW'(1);
        end else begin
            state       <= state_next;
            flush_index <= flush_index_next;
        end
    end

    // Next-state: a flush request always (re)starts the walk at register 1.
    always_comb begin
        state_next       = state;
        flush_index_next = flush_index;
        unique case (state)
            IDLE: begin
                if (bus.flush) begin
                    state_next       = FLUSH;
                    flush_index_next = RW'(1);
                end
            end
            FLUSH: begin
                if (bus.flush) begin
                    flush_index_next = RW'(1);
                end else if (flush_index == RW'(REG_COUNT - 1)) begin
                    state_next       = IDLE;
                    flush_index_next = RW'(1);
                end else begin
                    flush_index_next = flush_index + RW'(1);
                end
            end
            default: begin
                state_next       = FLUSH;
                flush_index_next = RW'(1);
            end
        endcase
    end

    // Output decode; issue to register 0 is accepted without a write.
    always_comb begin
        bus.issueReady       = 1'b0;
        bus.flushBusy        = 1'b0;
        bus.tableWriteEnable = 1'b0;
        bus.tableWriteIndex  = '0;
        bus.tableWriteValue  = '0;
        unique case (state)
            FLUSH: begin
                bus.flushBusy        = 1'b1;
                bus.tableWriteEnable = 1'b1;
                bus.tableWriteIndex  = flush_index;
            end
            IDLE: begin
                if (!bus.flush) begin
                    if (commit_match_c) begin
                        bus.tableWriteEnable = 1'b1;
                        bus.tableWriteIndex  = bus.commitDest;
                    end else begin
                        bus.issueReady = 1'b1;
                        if (bus.issueValid && (bus.issueDest != '0)) begin
                            bus.tableWriteEnable = 1'b1;
                            bus.tableWriteIndex  = bus.issueDest;
                            bus.tableWriteValue  = VW'({1'b1, bus.issueTag});
                        end
                    end
                end
            end
            default: begin
                bus.flushBusy = 1'b1;
            end
        endcase
    end
endmodule
